// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO read-side arbiter.
package fifo_arb_pkg;

  // The arbiter is either deciding who goes next or serving one owner's burst.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_rd_arb_rr_pick.sv
// Combinational round-robin picker: finds the first asserted request after
// the previous owner, wrapping modulo N_REQ (works for non-power-of-2 N_REQ).
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IW = $clog2(N_REQ);

  // Scan last+1, last+2, ... and keep the first hit; last itself is scanned last.
  always_comb begin
    int pos;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      pos = (int'(last) + i) % N_REQ;
      if (!found && req[IW'(pos)]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arb.sv
// Read-side scheduler for the async FIFO: shares the single read port among
// N_REQ consumers, round-robin, in bursts of up to MAX_BURST pops, and returns
// each popped word tagged with its owner one cycle after the pop.
module fifo_rd_arb
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DWIDTH    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     empty,
  input  logic [DWIDTH-1:0]        r_data,
  output logic                     r_en,
  output logic [N_REQ-1:0]         grant,
  output logic                     rd_valid,
  output logic [DWIDTH-1:0]        rd_data,
  output logic [$clog2(N_REQ)-1:0] rd_id
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);

  arb_state_t       state, state_next;
  logic [IW-1:0]    owner, owner_next;
  logic [IW-1:0]    last, last_next;
  logic [BW-1:0]    beat, beat_next;
  logic [N_REQ-1:0] grant_next;
  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic             pop;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req  (req),
    .last (last),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // Arbiter state; last starts at N_REQ-1 so requester 0 wins the first round.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last  <= LAST_INIT;
      beat  <= '0;
      grant <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      last  <= last_next;
      beat  <= beat_next;
      grant <= grant_next;
    end
  end

  // Next-state and pop decision; pop is gated by rst so a burst stops in the reset cycle.
  always_comb begin
    state_next = state;
    owner_next = owner;
    last_next  = last;
    beat_next  = beat;
    grant_next = grant;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found && !empty) begin
          state_next = BURST;
          owner_next = pick_idx;
          grant_next = N_REQ'(1) << pick_idx;
          beat_next  = '0;
        end
      end
      BURST: begin
        pop = req[owner] && !empty && !rst;
        if (pop) begin
          beat_next = beat + 1'b1;
        end
        if (!pop || beat == LAST_BEAT) begin
          state_next = IDLE;
          last_next  = owner;
          grant_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign r_en = pop;

  // Return path: the popped word and its owner appear one cycle after the pop and then hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_id    <= '0;
    end else begin
      rd_valid <= r_en;
      if (r_en) begin
        rd_data <= r_data;
        rd_id   <= owner;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Directed bench for fifo_rd_arb with N_REQ=4, DWIDTH=8, MAX_BURST=4.
// A tiny FIFO stand-in supplies words 0xC0, 0xC1, ... counted from a mark.
module tb_fifo_rd_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       empty;
  logic [7:0] r_data;
  logic       r_en;
  logic [3:0] grant;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [1:0] rd_id;

  logic force_empty;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   mark   = 0;
  int   total  = 0;
  int   bad    = 0;

  logic exp_ren;
  logic prev_ren;

  fifo_rd_arb #(
    .N_REQ    (4),
    .DWIDTH   (8),
    .MAX_BURST(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .empty   (empty),
    .r_data  (r_data),
    .r_en    (r_en),
    .grant   (grant),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .rd_id   (rd_id)
  );

  // Free-running read clock.
  always #5 clk = ~clk;

  assign empty  = force_empty || (wr_cnt == rd_cnt);
  assign r_data = 8'hC0 + 8'(rd_cnt - mark);

  // FIFO stand-in: each pop advances the read count.
  always @(posedge clk) begin
    if (r_en) rd_cnt <= rd_cnt + 1;
  end

  task automatic applyStimulus(input logic r, input logic [3:0] q, input logic fe);
    rst         = r;
    req         = q;
    force_empty = fe;
    #1;
  endtask

  task automatic fillFifo(input int n);
    mark   = rd_cnt;
    wr_cnt = rd_cnt + n;
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    #1;

    // Reset state
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_ren", 32'(r_en), 32'h0);
    checkOutput("rst_valid", 32'(rd_valid), 32'h0);
    checkOutput("rst_data", 32'(rd_data), 32'h0);
    checkOutput("rst_id", 32'(rd_id), 32'h0);

    // Single requester, single word
    fillFifo(1);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkOutput("t1_idle_ren", 32'(r_en), 32'h0);
    nextCycle();
    checkOutput("t1_grant", 32'(grant), 32'h1);
    checkOutput("t1_ren", 32'(r_en), 32'h1);
    nextCycle();
    checkOutput("t1_valid", 32'(rd_valid), 32'h1);
    checkOutput("t1_id", 32'(rd_id), 32'h0);
    checkOutput("t1_data", 32'(rd_data), 32'hC0);
    checkOutput("t1_ren_empty", 32'(r_en), 32'h0);
    nextCycle();
    checkOutput("t1_grant_exit", 32'(grant), 32'h0);
    checkOutput("t1_valid_off", 32'(rd_valid), 32'h0);
    applyStimulus(1'b0, 4'b0000, 1'b0);

    // Fairness: fresh reset, all requesting, FIFO never empty
    applyStimulus(1'b1, 4'b0000, 1'b0);
    nextCycle();
    fillFifo(1000);
    applyStimulus(1'b0, 4'b1111, 1'b0);
    for (int i = 0; i <= 20; i++) begin
      exp_ren = (i % 5) != 0;
      checkOutput($sformatf("t2_ren_%0d", i), 32'(r_en), 32'(exp_ren));
      checkOutput($sformatf("t2_grant_%0d", i), 32'(grant),
                  exp_ren ? (32'h1 << ((i / 5) % 4)) : 32'h0);
      if (i > 0) begin
        prev_ren = ((i - 1) % 5) != 0;
        checkOutput($sformatf("t2_valid_%0d", i), 32'(rd_valid), 32'(prev_ren));
        if (prev_ren) begin
          checkOutput($sformatf("t2_id_%0d", i), 32'(rd_id), 32'(((i - 1) / 5) % 4));
        end
      end
      if (i < 20) nextCycle();
    end
    applyStimulus(1'b0, 4'b0000, 1'b0);
    nextCycle();

    // Owner 2 drops req after two pops; next turn goes to 3
    applyStimulus(1'b0, 4'b0100, 1'b0);
    checkOutput("t3_idle_ren", 32'(r_en), 32'h0);
    nextCycle();
    checkOutput("t3_grant", 32'(grant), 32'h4);
    checkOutput("t3_ren0", 32'(r_en), 32'h1);
    nextCycle();
    checkOutput("t3_ren1", 32'(r_en), 32'h1);
    checkOutput("t3_valid0", 32'(rd_valid), 32'h1);
    checkOutput("t3_id0", 32'(rd_id), 32'h2);
    nextCycle();
    applyStimulus(1'b0, 4'b1011, 1'b0);
    checkOutput("t3_ren_drop", 32'(r_en), 32'h0);
    checkOutput("t3_grant_hold", 32'(grant), 32'h4);
    checkOutput("t3_valid1", 32'(rd_valid), 32'h1);
    checkOutput("t3_id1", 32'(rd_id), 32'h2);
    nextCycle();
    checkOutput("t3_grant_exit", 32'(grant), 32'h0);
    checkOutput("t3_ren_idle", 32'(r_en), 32'h0);
    checkOutput("t3_valid_off", 32'(rd_valid), 32'h0);
    nextCycle();
    checkOutput("t3_next_grant", 32'(grant), 32'h8);
    checkOutput("t3_next_ren", 32'(r_en), 32'h1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    nextCycle();
    checkOutput("t3_final_grant", 32'(grant), 32'h0);

    // FIFO holds three words; burst ends early on empty
    fillFifo(3);
    applyStimulus(1'b0, 4'b0010, 1'b0);
    checkOutput("t4_idle_ren", 32'(r_en), 32'h0);
    nextCycle();
    checkOutput("t4_grant", 32'(grant), 32'h2);
    checkOutput("t4_ren0", 32'(r_en), 32'h1);
    nextCycle();
    checkOutput("t4_ren1", 32'(r_en), 32'h1);
    checkOutput("t4_valid0", 32'(rd_valid), 32'h1);
    checkOutput("t4_data0", 32'(rd_data), 32'hC0);
    checkOutput("t4_id0", 32'(rd_id), 32'h1);
    nextCycle();
    checkOutput("t4_ren2", 32'(r_en), 32'h1);
    checkOutput("t4_data1", 32'(rd_data), 32'hC1);
    nextCycle();
    checkOutput("t4_ren_empty", 32'(r_en), 32'h0);
    checkOutput("t4_grant_hold", 32'(grant), 32'h2);
    checkOutput("t4_valid2", 32'(rd_valid), 32'h1);
    checkOutput("t4_data2", 32'(rd_data), 32'hC2);
    nextCycle();
    checkOutput("t4_grant_exit", 32'(grant), 32'h0);
    checkOutput("t4_valid_off", 32'(rd_valid), 32'h0);
    checkOutput("t4_data_hold", 32'(rd_data), 32'hC2);
    checkOutput("t4_id_hold", 32'(rd_id), 32'h1);
    checkOutput("t4_ren_idle", 32'(r_en), 32'h0);

    // Empty glitch mid-burst forfeits the rest of owner 0's burst
    fillFifo(10);
    applyStimulus(1'b0, 4'b0011, 1'b0);
    checkOutput("t5_idle_ren", 32'(r_en), 32'h0);
    nextCycle();
    checkOutput("t5_grant", 32'(grant), 32'h1);
    checkOutput("t5_ren0", 32'(r_en), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 4'b0011, 1'b1);
    checkOutput("t5_ren_empty", 32'(r_en), 32'h0);
    checkOutput("t5_grant_hold", 32'(grant), 32'h1);
    checkOutput("t5_valid0", 32'(rd_valid), 32'h1);
    checkOutput("t5_id0", 32'(rd_id), 32'h0);
    checkOutput("t5_data0", 32'(rd_data), 32'hC0);
    nextCycle();
    applyStimulus(1'b0, 4'b0011, 1'b0);
    checkOutput("t5_grant_exit", 32'(grant), 32'h0);
    checkOutput("t5_ren_idle", 32'(r_en), 32'h0);
    checkOutput("t5_valid_off", 32'(rd_valid), 32'h0);
    nextCycle();
    checkOutput("t5_next_grant", 32'(grant), 32'h2);
    checkOutput("t5_next_ren", 32'(r_en), 32'h1);

    // Reset in the middle of a burst
    nextCycle();
    checkOutput("t6_valid_pre", 32'(rd_valid), 32'h1);
    checkOutput("t6_id_pre", 32'(rd_id), 32'h1);
    checkOutput("t6_data_pre", 32'(rd_data), 32'hC1);
    checkOutput("t6_ren_pre", 32'(r_en), 32'h1);
    applyStimulus(1'b1, 4'b0011, 1'b0);
    checkOutput("t6_ren_in_rst", 32'(r_en), 32'h0);
    nextCycle();
    checkOutput("t6_grant", 32'(grant), 32'h0);
    checkOutput("t6_valid", 32'(rd_valid), 32'h0);
    checkOutput("t6_id", 32'(rd_id), 32'h0);
    checkOutput("t6_data", 32'(rd_data), 32'h0);
    applyStimulus(1'b0, 4'b0011, 1'b0);
    checkOutput("t6_idle_ren", 32'(r_en), 32'h0);
    nextCycle();
    checkOutput("t6_first_grant", 32'(grant), 32'h1);
    checkOutput("t6_first_ren", 32'(r_en), 32'h1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
